// File: rtl/debug_host_link.sv
// Host-side debug link: sends one command byte over the UART transmitter, then
// collects the reply bytes from the UART receiver and assembles them into words.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for i_start; stray rx bytes dropped
// SEND     | one-cycle start pulse to the transmitter with the command byte
// WAIT_TX  | waiting for tx_done; early reply bytes are already collected
// RECV     | collecting reply bytes under the inter-byte timeout
// DONE     | one-cycle completion pulse
// TIMEOUT  | one-cycle abort pulse; partial word dropped
module debug_host_link #(
    parameter  int NB             = 32,
    parameter  int DATA_BITS      = 8,
    parameter  int MAX_WORDS      = 16,
    parameter  int TIMEOUT_CYCLES = 2000000,
    localparam int NW_W           = $clog2(MAX_WORDS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_cmd,
    input  logic [NW_W-1:0]      i_num_words,
    input  logic                 i_uart_tx_done,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    output logic                 o_uart_tx_ready,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic [NB-1:0]        o_word,
    output logic                 o_word_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [3:0]           o_state_debug
);

    localparam int BPW  = NB / DATA_BITS;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BPW - 1);
    localparam logic [TO_W-1:0] TO_TERM   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NW_W-1:0] NW_MAX    = NW_W'(MAX_WORDS);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SEND    = 4'd1;
    localparam logic [3:0] WAIT_TX = 4'd2;
    localparam logic [3:0] RECV    = 4'd3;
    localparam logic [3:0] DONE    = 4'd4;
    localparam logic [3:0] TIMEOUT = 4'd5;

    logic [3:0]           state;
    logic [DATA_BITS-1:0] cmd_q;
    logic [NW_W-1:0]      num_words_q;
    logic [NW_W-1:0]      word_cnt;
    logic [BC_W-1:0]      byte_cnt;
    logic [NB-1:0]        shreg;
    logic [NB-1:0]        word_next;
    logic [TO_W-1:0]      to_cnt;
    logic [NB-1:0]        word_q;
    logic                 word_valid_q;
    logic                 words_left;
    logic                 rx_take;

    assign words_left = (word_cnt != num_words_q);
    // Reply bytes count in WAIT_TX too: the target may answer before our stop bit ends.
    assign rx_take    = i_uart_rx_ready && words_left && ((state == WAIT_TX) || (state == RECV));

    always_comb begin
        word_next = shreg;
        word_next[int'(byte_cnt) * DATA_BITS +: DATA_BITS] = i_uart_rx_data;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            cmd_q        <= '0;
            num_words_q  <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            shreg        <= '0;
            to_cnt       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;

            if (rx_take) begin
                shreg  <= word_next;
                to_cnt <= '0;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt     <= '0;
                    word_cnt     <= word_cnt + 1'b1;
                    word_q       <= word_next;
                    word_valid_q <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        cmd_q       <= i_cmd;
                        num_words_q <= (i_num_words > NW_MAX) ? NW_MAX : i_num_words;
                        word_cnt    <= '0;
                        byte_cnt    <= '0;
                        shreg       <= '0;
                        to_cnt      <= '0;
                        state       <= SEND;
                    end
                end
                SEND: state <= WAIT_TX;
                WAIT_TX: begin
                    if (i_uart_tx_done) begin
                        to_cnt <= '0;
                        state  <= words_left ? RECV : DONE;
                    end
                end
                RECV: begin
                    // Completion is taken the cycle after the last word, so o_done trails o_word_valid.
                    if (!words_left) begin
                        state <= DONE;
                    end else if (!i_uart_rx_ready) begin
                        if (to_cnt == TO_TERM) begin
                            state <= TIMEOUT;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                TIMEOUT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_uart_tx_ready = (state == SEND);
    assign o_uart_tx_data  = cmd_q;
    assign o_word          = word_q;
    assign o_word_valid    = word_valid_q;
    assign o_busy          = (state != IDLE);
    assign o_done          = (state == DONE);
    assign o_timeout       = (state == TIMEOUT);
    assign o_state_debug   = state;

endmodule

// File: doc/debug_host_link.md
Name: debug_host_link

Overview:
- Host-end counterpart of the on-chip debug unit. It sends one command byte through the UART transmitter, then collects the debug unit's reply bytes from the UART receiver and assembles them into 32-bit words.
- Sits between the UART Receptor/Transmisor pair and a host-side controller, either an FPGA test harness or the loopback bench.
- Single clock domain.

Parameters:
- NB, 32: width of an assembled reply word in bits; must be a multiple of DATA_BITS.
- DATA_BITS, 8: UART byte width.
- MAX_WORDS, 16: maximum reply words per command; i_num_words width is clog2(MAX_WORDS+1).
- TIMEOUT_CYCLES, 2000000: idle clocks allowed between consecutive expected bytes before aborting.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous reset, active-low (0 = reset).
- i_start  input  1  one-cycle request to issue a command; ignored unless idle.
- i_cmd  input  DATA_BITS  command byte, sampled when i_start is accepted.
- i_num_words  input  clog2(MAX_WORDS+1)  reply words expected, sampled with i_cmd; 0 means command only, no reply.
- i_uart_tx_done  input  1  one-cycle pulse from Transmisor when the byte is fully shifted out.
- i_uart_rx_ready  input  1  one-cycle pulse from Receptor when a byte is valid.
- i_uart_rx_data  input  DATA_BITS  received byte, valid with i_uart_rx_ready.
- o_uart_tx_ready  output  1  one-cycle start pulse to Transmisor.
- o_uart_tx_data  output  DATA_BITS  byte to transmit; held stable from the start pulse until tx_done.
- o_word  output  NB  last assembled reply word.
- o_word_valid  output  1  one-cycle pulse when o_word updates.
- o_busy  output  1  high in any state except IDLE.
- o_done  output  1  one-cycle pulse on successful completion.
- o_timeout  output  1  one-cycle pulse on abort by timeout.
- o_state_debug  output  4  encoded FSM state for LEDs.

Behaviour:
- Reset values (i_reset=0, asynchronous):
  - All outputs 0; o_state_debug = IDLE encoding.
  - Internal byte counter, word counter, shift register and timeout counter cleared.
  - A transfer in progress is abandoned silently, with no o_done or o_timeout pulse.
- State encodings: IDLE=0, SEND=1, WAIT_TX=2, RECV=3, DONE=4, TIMEOUT=5.
- IDLE:
  - On i_start=1, latch i_cmd and i_num_words and go to SEND.
  - i_uart_rx_ready pulses in IDLE are discarded.
- SEND: assert o_uart_tx_ready for exactly one cycle with o_uart_tx_data = latched command, then go to WAIT_TX.
- WAIT_TX:
  - Wait for i_uart_tx_done; this wait has no timeout.
  - On tx_done, go to DONE if num_words=0, otherwise go to RECV and clear the timeout counter.
  - Reply bytes arriving in WAIT_TX (including the tx_done cycle) are accepted as RECV data; the debug unit may answer before the local stop bit completes.
- RECV, on each i_uart_rx_ready:
  - Place the byte into the shift register least-significant byte first: byte k goes to bits [8k+7:8k].
  - Increment the byte counter and clear the timeout counter.
  - When NB/DATA_BITS bytes have been collected:
    - o_word takes the full word and o_word_valid pulses on the next cycle (latency 1 clock after the last rx_ready).
    - The byte counter wraps to 0 and the word counter increments.
    - When the word counter reaches num_words, go to DONE.
- Timeout in RECV (and in WAIT_TX only after tx_done has been seen):
  - The timeout counter increments every cycle without rx_ready.
  - When it reaches TIMEOUT_CYCLES-1, go to TIMEOUT; partial-word bytes are dropped and o_word is not updated.
- Simultaneous rx_ready and timeout terminal count: the byte wins and the counter clears.
- DONE: o_done pulses for 1 cycle, then IDLE.
- TIMEOUT: o_timeout pulses for 1 cycle, then IDLE.
- i_start while busy: ignored, no queuing.
- i_num_words > MAX_WORDS: clamped to MAX_WORDS.
- Extra rx bytes after DONE: discarded in IDLE.

Test Plan:
- Reset mid-RECV (after 2 of 4 bytes): assert i_reset=0 -> all outputs 0 immediately (async); after release, a new i_start cmd=0x05, num_words=1 completes normally with no stale bytes.
- i_start cmd=0xA1, num_words=1, tx_done after 10 cycles, rx bytes 0xA3,0xFF,0x00,0x00 -> o_uart_tx_ready pulses once with data 0xA1; o_word=0x0000FFA3 with o_word_valid 1 cycle after the 4th byte; o_done pulses next; o_busy falls.
- cmd=0x10, num_words=3, 12 bytes 0x00..0x0B -> o_word_valid pulses ×3 with words 0x03020100, 0x07060504, 0x0B0A0908, then o_done.
- cmd=0x22, num_words=0 -> tx pulse, tx_done, o_done with no o_word_valid; rx bytes injected afterward are ignored.
- TIMEOUT_CYCLES=50, num_words=1, only 2 bytes sent -> o_timeout pulses 50 cycles after the 2nd byte; o_word unchanged; o_done never asserted.
- i_start pulsed again during RECV with cmd=0x99 -> no second o_uart_tx_ready; the current transfer finishes unaffected.
